// File: rtl/id_stage_hs_if.sv
// Decode-stage bus: upstream fetch handshake, regfile read port, downstream
// issue handshake and status. slave = decode stage, master = its environment.
interface id_stage_hs_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int IMM_WIDTH  = 8,
  parameter int DEPTH      = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_WIDTH-1:0]   pc_i;
  logic [15:0]             instr_i;
  logic [REG_WIDTH-1:0]    rf_ra1_o;
  logic [REG_WIDTH-1:0]    rf_ra2_o;
  logic [DATA_WIDTH-1:0]   rf_rd1_i;
  logic [DATA_WIDTH-1:0]   rf_rd2_i;
  logic                    flush_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_WIDTH-1:0]   pc_o;
  logic [REG_WIDTH-1:0]    rs_o;
  logic [REG_WIDTH-1:0]    rt_o;
  logic [REG_WIDTH-1:0]    rd_o;
  logic [DATA_WIDTH-1:0]   rs_data_o;
  logic [DATA_WIDTH-1:0]   rt_data_o;
  logic [DATA_WIDTH-1:0]   imm_o;
  logic [8:0]              ctrl_o;
  logic                    jump_o;
  logic [IMM_WIDTH-1:0]    jump_addr_o;
  logic                    halted_o;
  logic [$clog2(DEPTH):0]  count_o;

  modport slave (
    input  in_valid, pc_i, instr_i, rf_rd1_i, rf_rd2_i, flush_i, out_ready,
    output in_ready, rf_ra1_o, rf_ra2_o, out_valid, pc_o, rs_o, rt_o, rd_o,
           rs_data_o, rt_data_o, imm_o, ctrl_o, jump_o, jump_addr_o,
           halted_o, count_o
  );

  modport master (
    output in_valid, pc_i, instr_i, rf_rd1_i, rf_rd2_i, flush_i, out_ready,
    input  in_ready, rf_ra1_o, rf_ra2_o, out_valid, pc_o, rs_o, rt_o, rd_o,
           rs_data_o, rt_data_o, imm_o, ctrl_o, jump_o, jump_addr_o,
           halted_o, count_o
  );
endinterface

// File: rtl/id_stage_hs.sv
// Decode stage: decodes, reads regfile and queues entries for issue; latency 1 cycle.
// Backpressure: in_ready drops when the queue is full and not popping, on flush, or once halted.
module id_stage_hs #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int IMM_WIDTH  = 8,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  id_stage_hs_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0]  rs;
    logic [REG_WIDTH-1:0]  rt;
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] rsData;
    logic [DATA_WIDTH-1:0] rtData;
    logic [DATA_WIDTH-1:0] imm;
    logic [8:0]            ctrl;
  } entryT;

  typedef enum logic {RUN, HALTED} stateT;

  entryT         mem [DEPTH];
  entryT         inEntry;
  entryT         headEntry;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  stateT         state;
  stateT         stateNext;
  logic [3:0]    opcode;
  logic [8:0]    ctrlDec;
  logic          outValid;
  logic          inReady;
  logic          accept;
  logic          pop;

  assign opcode = bus.instr_i[15:12];

  // Control word order: RegWrite, ALUop, Branch, MemRead, RegDst, MemWrite, MemToReg, Mov, Floating
  always_comb begin
    ctrlDec = 9'b000000000;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3: ctrlDec = 9'b110010000;
      4'h4:                   ctrlDec = 9'b100100100;
      4'h5:                   ctrlDec = 9'b000001000;
      4'h6:                   ctrlDec = 9'b011000000;
      4'h8:                   ctrlDec = 9'b100000010;
      4'h9:                   ctrlDec = 9'b110010001;
      default:                ctrlDec = 9'b000000000;
    endcase
  end

  assign outValid = (count != '0);
  // A full queue still accepts when the head leaves in the same cycle
  assign inReady  = (state == RUN) && !bus.flush_i &&
                    ((count < FULL) || (outValid && bus.out_ready));
  assign accept   = bus.in_valid && inReady;
  assign pop      = outValid && bus.out_ready && !bus.flush_i;

  always_comb begin
    inEntry        = '0;
    inEntry.pc     = bus.pc_i;
    inEntry.rs     = REG_WIDTH'(bus.instr_i[11:8]);
    inEntry.rt     = REG_WIDTH'(bus.instr_i[7:4]);
    inEntry.rd     = REG_WIDTH'(bus.instr_i[3:0]);
    inEntry.rsData = bus.rf_rd1_i;
    inEntry.rtData = bus.rf_rd2_i;
    inEntry.imm    = DATA_WIDTH'($signed(bus.instr_i[IMM_WIDTH-1:0]));
    inEntry.ctrl   = ctrlDec;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= inEntry;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (pop)    head <= head + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  // HALTED is sticky; only reset brings the stage back
  always_comb begin
    stateNext = state;
    if (state == RUN && accept && opcode == 4'hF) stateNext = HALTED;
  end

  // Storage is not reset, so the head is masked while the queue is empty
  assign headEntry = outValid ? mem[head] : '0;

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValid;
  assign bus.rf_ra1_o    = REG_WIDTH'(bus.instr_i[11:8]);
  assign bus.rf_ra2_o    = REG_WIDTH'(bus.instr_i[7:4]);
  assign bus.pc_o        = headEntry.pc;
  assign bus.rs_o        = headEntry.rs;
  assign bus.rt_o        = headEntry.rt;
  assign bus.rd_o        = headEntry.rd;
  assign bus.rs_data_o   = headEntry.rsData;
  assign bus.rt_data_o   = headEntry.rtData;
  assign bus.imm_o       = headEntry.imm;
  assign bus.ctrl_o      = headEntry.ctrl;
  assign bus.jump_o      = accept && (opcode == 4'h7);
  assign bus.jump_addr_o = bus.instr_i[IMM_WIDTH-1:0];
  assign bus.halted_o    = (state == HALTED);
  assign bus.count_o     = count;
endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: directed scenarios then random traffic, checked by a
// queue-based reference model with a separate output monitor.
module tb_id_stage_hs;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_hs_if #(.DEPTH(DEPTH)) bus ();

  id_stage_hs #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0]  pc;
    logic [3:0]  rs, rt, rd;
    logic [15:0] rsData, rtData, imm;
    logic [8:0]  ctrl;
  } expT;

  expT        expQ[$];
  logic [8:0] ctrlTab [16];
  logic       haltedM = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, advance the model
  task automatic step(input logic v, input logic [15:0] ins, input logic [7:0] pcv,
                      input logic [15:0] d1, input logic [15:0] d2,
                      input logic ordy, input logic fl, input logic rs);
    logic expRdy;
    expT  e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.instr_i   = ins;
    bus.pc_i      = pcv;
    bus.rf_rd1_i  = d1;
    bus.rf_rd2_i  = d2;
    bus.out_ready = ordy;
    bus.flush_i   = fl;
    rst           = rs;
    #1;
    if (rs) begin
      expQ.delete();
      haltedM = 1'b0;
    end else begin
      expRdy = !haltedM && !fl && (expQ.size() < DEPTH || (expQ.size() > 0 && ordy));
      check("in_ready", bus.in_ready, expRdy);
      check("count", bus.count_o, expQ.size());
      check("out_valid", bus.out_valid, expQ.size() != 0);
      check("halted", bus.halted_o, haltedM);
      check("ra1", bus.rf_ra1_o, ins[11:8]);
      check("ra2", bus.rf_ra2_o, ins[7:4]);
      check("jump", bus.jump_o, v && expRdy && ins[15:12] == 4'h7);
      check("jump_addr", bus.jump_addr_o, ins[7:0]);
      if (expQ.size() == 0)
        check("empty_payload", {bus.pc_o, bus.ctrl_o, bus.imm_o}, 0);
      if (v && expRdy) begin
        e.pc = pcv; e.rs = ins[11:8]; e.rt = ins[7:4]; e.rd = ins[3:0];
        e.rsData = d1; e.rtData = d2;
        e.imm = {{8{ins[7]}}, ins[7:0]};
        e.ctrl = ctrlTab[ins[15:12]];
        expQ.push_back(e);
        if (ins[15:12] == 4'hF) haltedM = 1'b1;
      end
      if (fl) expQ.delete();
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0000, 8'h00, 16'h0000, 16'h0000, ordy, 1'b0, 1'b0);
  endtask

  // Monitor: compares the presented head against the scoreboard every valid cycle
  initial begin
    expT h;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !bus.flush_i && bus.out_valid) begin
        if (expQ.size() == 0) begin
          check("unexpected_out", bus.out_valid, 0);
        end else begin
          h = expQ[0];
          check("pc_o", bus.pc_o, h.pc);
          check("rs_o", bus.rs_o, h.rs);
          check("rt_o", bus.rt_o, h.rt);
          check("rd_o", bus.rd_o, h.rd);
          check("rs_data_o", bus.rs_data_o, h.rsData);
          check("rt_data_o", bus.rt_data_o, h.rtData);
          check("imm_o", bus.imm_o, h.imm);
          check("ctrl_o", bus.ctrl_o, h.ctrl);
          if (bus.out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    logic        v, ordy, fl, rs;
    logic [15:0] ins;
    for (int i = 0; i < 16; i++) ctrlTab[i] = 9'b000000000;
    for (int i = 0; i < 4; i++)  ctrlTab[i] = 9'b110010000;
    ctrlTab[4] = 9'b100100100;
    ctrlTab[5] = 9'b000001000;
    ctrlTab[6] = 9'b011000000;
    ctrlTab[8] = 9'b100000010;
    ctrlTab[9] = 9'b110010001;

    bus.in_valid = 1'b0; bus.instr_i = '0; bus.pc_i = '0; bus.rf_rd1_i = '0;
    bus.rf_rd2_i = '0; bus.out_ready = 1'b0; bus.flush_i = 1'b0;

    step(0, 16'h0, 8'h0, 16'h0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 8'h0, 16'h0, 16'h0, 0, 0, 1);
    idle(0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_count", bus.count_o, 0);

    // Basic ADD with regfile data
    step(1, 16'h1234, 8'h10, 16'h00AA, 16'h0055, 1, 0, 0);
    idle(0);
    check("add_valid", bus.out_valid, 1);
    check("add_pc", bus.pc_o, 8'h10);
    check("add_rs", bus.rs_o, 2);
    check("add_rt", bus.rt_o, 3);
    check("add_rd", bus.rd_o, 4);
    check("add_rs_data", bus.rs_data_o, 16'h00AA);
    check("add_rt_data", bus.rt_data_o, 16'h0055);
    check("add_ctrl", bus.ctrl_o, 9'b110010000);
    check("add_imm", bus.imm_o, 16'h0034);
    idle(1);

    // Sign-extended immediate, then LW pushed while MOVI pops
    step(1, 16'h80F0, 8'h11, 16'h1, 16'h2, 0, 0, 0);
    idle(0);
    check("movi_imm", bus.imm_o, 16'hFFF0);
    check("movi_ctrl", bus.ctrl_o, 9'b100000010);
    step(1, 16'h4000, 8'h12, 16'h3, 16'h4, 1, 0, 0);
    idle(0);
    check("lw_ctrl", bus.ctrl_o, 9'b100100100);
    idle(1);

    // Fill, stall, then pop+push on full
    step(1, 16'h1111, 8'h20, 16'h5, 16'h6, 0, 0, 0);
    step(1, 16'h2222, 8'h21, 16'h7, 16'h8, 0, 0, 0);
    step(1, 16'h3333, 8'h22, 16'h9, 16'hA, 0, 0, 0);
    check("full_in_ready", bus.in_ready, 0);
    check("full_count", bus.count_o, 2);
    step(1, 16'h3333, 8'h22, 16'h9, 16'hA, 1, 0, 0);
    check("full_pop_push_ready", bus.in_ready, 1);
    idle(0);
    check("full_pop_push_count", bus.count_o, 2);
    check("full_order", bus.pc_o, 8'h21);
    idle(1);
    idle(1);

    // JMP
    step(1, 16'h7042, 8'h30, 16'h0, 16'h0, 0, 0, 0);
    check("jmp_jump", bus.jump_o, 1);
    check("jmp_addr", bus.jump_addr_o, 8'h42);
    idle(0);
    check("jmp_ctrl", bus.ctrl_o, 0);
    check("jmp_pc", bus.pc_o, 8'h30);
    idle(1);

    // Flush with a full queue and a pending input
    step(1, 16'h1234, 8'h31, 16'h0, 16'h0, 0, 0, 0);
    step(1, 16'h2345, 8'h32, 16'h0, 16'h0, 0, 0, 0);
    step(1, 16'h7456, 8'h33, 16'h0, 16'h0, 1, 1, 0);
    check("flush_ready", bus.in_ready, 0);
    check("flush_jump", bus.jump_o, 0);
    idle(0);
    check("flush_count", bus.count_o, 0);
    check("flush_valid", bus.out_valid, 0);

    // HALT, drain, then reset recovers
    step(1, 16'hF000, 8'h40, 16'h0, 16'h0, 0, 0, 0);
    step(1, 16'h1234, 8'h41, 16'h0, 16'h0, 0, 0, 0);
    check("halt_flag", bus.halted_o, 1);
    check("halt_ready", bus.in_ready, 0);
    check("halt_count", bus.count_o, 1);
    idle(1);
    step(1, 16'h1234, 8'h42, 16'h0, 16'h0, 0, 1, 0);
    idle(0);
    check("halt_after_flush", bus.halted_o, 1);
    check("halt_drained", bus.count_o, 0);
    step(0, 16'h0, 8'h0, 16'h0, 16'h0, 0, 0, 1);
    idle(0);
    check("halt_reset_ready", bus.in_ready, 1);
    check("halt_reset_flag", bus.halted_o, 0);

    // Random traffic with occasional flush, halt and reset
    for (int i = 0; i < 2000; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ins  = 16'($urandom);
      if (ins[15:12] == 4'hF && $urandom_range(0, 7) != 0) ins[15:12] = 4'h0;
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      rs   = ($urandom_range(0, 79) == 0);
      step(v, ins, 8'($urandom), 16'($urandom), 16'($urandom), ordy, fl, rs);
    end

    idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_hs.md
ID_STAGE_HS -- requirements
Module: id_stage_hs

Interface
REQ-001 Params SHALL be: DATA_WIDTH=16 (datapath width); ADDR_WIDTH=8 (PC width); REG_WIDTH=4 (register index width); IMM_WIDTH=8 (raw immediate width, <=DATA_WIDTH); DEPTH=2 (output queue entries, power of 2, >=2).
REQ-002 clk input 1: clock; rst input 1: reset, synchronous, active-high.
REQ-003 in_valid input 1 / in_ready output 1: upstream handshake; transfer when both high at posedge.
REQ-004 pc_i input ADDR_WIDTH; instr_i input 16: fetched instruction.
REQ-005 rf_ra1_o, rf_ra2_o output REG_WIDTH: regfile read addresses; rf_rd1_i, rf_rd2_i input DATA_WIDTH: same-cycle read data.
REQ-006 flush_i input 1: discard all queued and incoming instructions.
REQ-007 out_valid output 1 / out_ready input 1: downstream handshake.
REQ-008 Payload outputs: pc_o ADDR_WIDTH; rs_o, rt_o, rd_o REG_WIDTH; rs_data_o, rt_data_o DATA_WIDTH; imm_o DATA_WIDTH; ctrl_o 9 = {RegWrite, ALUop, Branch, MemRead, RegDst, MemWrite, MemToReg, Mov, Floating} (MSB first).
REQ-009 jump_o output 1, jump_addr_o output IMM_WIDTH; halted_o output 1; count_o output log2(DEPTH)+1: queue occupancy.

Function
REQ-010 Fields: opcode=instr_i[15:12], rs=[11:8], rt=[7:4], rd=[3:0], imm=[IMM_WIDTH-1:0].
REQ-011 rf_ra1_o=rs, rf_ra2_o=rt, combinational from instr_i.
REQ-012 Decode table (ctrl bits per REQ-008 order): 0 ADD 110010000; 1 SUB 110010000; 2 AND 110010000; 3 OR 110010000; 4 LW 100100100; 5 SW 000001000; 6 BEQ 011000000; 7 JMP 000000000; 8 MOVI 100000010; 9 FADD 110010001; F HALT 000000000; other opcodes 000000000 (NOP).
REQ-013 imm_o SHALL be imm sign-extended to DATA_WIDTH, captured at accept.
REQ-014 Accept (in_valid && in_ready) SHALL write one entry {pc_i, rs, rt, rd, rf_rd1_i, rf_rd2_i, sext imm, ctrl} at queue tail; payload appears at out_valid no earlier than next cycle (latency 1).
REQ-015 JMP and HALT SHALL still be enqueued (ctrl all zero) to preserve PC order.
REQ-016 in_ready = !halted_o && !flush_i && (count_o<DEPTH || (out_valid && out_ready)); simultaneous pop and push on full SHALL be allowed.
REQ-017 out_valid = (count_o!=0); payload outputs = head entry; pop on out_valid && out_ready.
REQ-018 Payload outputs SHALL hold stable while out_valid && !out_ready.
REQ-019 jump_o = in_valid && in_ready && opcode==7, combinational; jump_addr_o = instr_i[IMM_WIDTH-1:0] at all times.
REQ-020 States RUN, HALTED. RUN->HALTED on accept of opcode F; HALTED exits only via rst. halted_o=1 in HALTED; flush_i does not exit HALTED.
REQ-021 flush_i high at posedge SHALL empty the queue (count_o->0), no accept, no pop, jump_o=0 that cycle; flush has priority over all handshakes.
REQ-022 Queue pointers SHALL wrap modulo DEPTH; count_o never exceeds DEPTH nor underflows.
REQ-023 out_ready while empty SHALL have no effect.

Reset
REQ-024 rst SHALL have priority over flush_i and handshakes; when sampled high: count_o=0, pointers=0, out_valid=0, state RUN, halted_o=0; payload storage need not reset but payload outputs SHALL read 0 while empty.
REQ-025 rst mid-operation SHALL discard queued entries; in_ready=1 the cycle after rst deasserts (flush_i low).

Verification
REQ-026 After rst, instr 0x1234 pc 0x10, rf_rd1=0x00AA, rf_rd2=0x0055, out_ready=1 -> next cycle out_valid=1, pc_o=0x10, rs_o=2, rt_o=3, rd_o=4, rs_data_o=0x00AA, rt_data_o=0x0055, ctrl_o=110010000, imm_o=0x0034.
REQ-027 MOVI 0x80F0 -> imm_o=0xFFF0, ctrl_o=100000010; LW 0x4000 -> ctrl_o=100100100.
REQ-028 out_ready=0, push 3 instrs with DEPTH=2 -> count_o=2, in_ready=0 on third; raise out_ready with in_valid -> pop+push same cycle, count_o stays 2, order preserved.
REQ-029 JMP 0x7042 accepted -> jump_o=1, jump_addr_o=0x42 that cycle; queued with ctrl 0.
REQ-030 Queue holds 2 entries, flush_i=1 with in_valid=1 -> next cycle count_o=0, out_valid=0, nothing accepted.
REQ-031 HALT 0xF000 accepted -> halted_o=1, in_ready=0 permanently; queue drains normally; rst -> RUN, in_ready=1.
